// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups both master ports, the shared RAM port and the status outputs of mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the masters and models the RAM.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_arbiter_if;
   logic              m0_mem_req;
   logic              m0_mem_we;
   logic [`XLEN-1:0]  m0_mem_addr;
   logic [`XLEN-1:0]  m0_mem_wdata;
   logic [`XLEN-1:0]  m0_mem_rdata;
   logic              m0_mem_ready;

   logic              m1_mem_req;
   logic              m1_mem_we;
   logic [`XLEN-1:0]  m1_mem_addr;
   logic [`XLEN-1:0]  m1_mem_wdata;
   logic [`XLEN-1:0]  m1_mem_rdata;
   logic              m1_mem_ready;

   logic              ram_mem_req;
   logic              ram_mem_we;
   logic [`XLEN-1:0]  ram_mem_addr;
   logic [`XLEN-1:0]  ram_mem_wdata;
   logic [`XLEN-1:0]  ram_mem_rdata;
   logic              ram_mem_ready;

   logic [1:0]        grant;
   logic              timeout_err;

   modport slave (
      input  m0_mem_req, m0_mem_we, m0_mem_addr, m0_mem_wdata,
      output m0_mem_rdata, m0_mem_ready,
      input  m1_mem_req, m1_mem_we, m1_mem_addr, m1_mem_wdata,
      output m1_mem_rdata, m1_mem_ready,
      output ram_mem_req, ram_mem_we, ram_mem_addr, ram_mem_wdata,
      input  ram_mem_rdata, ram_mem_ready,
      output grant, timeout_err
   );

   modport master (
      output m0_mem_req, m0_mem_we, m0_mem_addr, m0_mem_wdata,
      input  m0_mem_rdata, m0_mem_ready,
      output m1_mem_req, m1_mem_we, m1_mem_addr, m1_mem_wdata,
      input  m1_mem_rdata, m1_mem_ready,
      input  ram_mem_req, ram_mem_we, ram_mem_addr, ram_mem_wdata,
      output ram_mem_rdata, ram_mem_ready,
      input  grant, timeout_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two masters share one RAM port; an access aborts after TIMEOUT unanswered BUSY cycles.
// Define ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_r, state_s;
   logic [1:0]        grant_r, grant_s;
   logic [CW-1:0]     cnt_r, cnt_s;
   logic              timeout_err_r, timeout_err_s;
   logic              any_req_s;
   logic              pick_m1_s;
   logic              own_req_s, own_we_s;
   logic [`XLEN-1:0]  own_addr_s, own_wdata_s;
   logic              hit_s, done_s, abort_s;

   assign any_req_s = bus.m0_mem_req | bus.m1_mem_req;

`ifdef ARB_RR_EN
   logic last_r;

   // On a tie, favour the master that did not take the previous grant
   always_comb begin
      pick_m1_s = 1'b0;
      if (bus.m0_mem_req && bus.m1_mem_req) begin
         pick_m1_s = ~last_r;
      end else begin
         pick_m1_s = bus.m1_mem_req;
      end
   end

   // Last-served master, updated on every grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= 1'b1;
      end else if (state_r == IDLE && any_req_s) begin
         last_r <= pick_m1_s;
      end else begin
         last_r <= last_r;
      end
   end
`else
   // Fixed priority: m1 wins only when m0 is not asking
   always_comb begin
      pick_m1_s = 1'b0;
      if (!bus.m0_mem_req && bus.m1_mem_req) begin
         pick_m1_s = 1'b1;
      end else begin
         pick_m1_s = 1'b0;
      end
   end
`endif

   // Select the current owner's request signals
   always_comb begin
      own_req_s   = 1'b0;
      own_we_s    = 1'b0;
      own_addr_s  = {`XLEN{1'b0}};
      own_wdata_s = {`XLEN{1'b0}};
      if (grant_r[1]) begin
         own_req_s   = bus.m1_mem_req;
         own_we_s    = bus.m1_mem_we;
         own_addr_s  = bus.m1_mem_addr;
         own_wdata_s = bus.m1_mem_wdata;
      end else if (grant_r[0]) begin
         own_req_s   = bus.m0_mem_req;
         own_we_s    = bus.m0_mem_we;
         own_addr_s  = bus.m0_mem_addr;
         own_wdata_s = bus.m0_mem_wdata;
      end else begin
         own_req_s   = 1'b0;
      end
   end

   // The current unanswered cycle would be the TIMEOUT-th one
   assign hit_s = (TIMEOUT != 0) && !bus.ram_mem_ready && (cnt_r >= CNT_LAST);

   // Next-state logic; owner drop beats completion, completion beats timeout
   always_comb begin
      state_s       = state_r;
      grant_s       = grant_r;
      cnt_s         = cnt_r;
      timeout_err_s = timeout_err_r;
      done_s        = 1'b0;
      abort_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s = BUSY;
               grant_s = pick_m1_s ? 2'b10 : 2'b01;
               cnt_s   = {CW{1'b0}};
            end else begin
               grant_s = 2'b00;
            end
         end
         BUSY: begin
            if (!own_req_s) begin
               state_s = IDLE;
               grant_s = 2'b00;
            end else if (bus.ram_mem_ready) begin
               done_s  = 1'b1;
               state_s = IDLE;
               grant_s = 2'b00;
            end else if (hit_s) begin
               abort_s       = 1'b1;
               timeout_err_s = 1'b1;
               state_s       = IDLE;
               grant_s       = 2'b00;
            end else if (cnt_r != CNT_MAX) begin
               cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = 2'b00;
         end
      endcase
   end

   // State, grant, counter and sticky error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         grant_r       <= 2'b00;
         cnt_r         <= {CW{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         cnt_r         <= cnt_s;
         timeout_err_r <= timeout_err_s;
      end
   end

   // RAM port follows the owner only while an access is live; readys go to the owner only
   always_comb begin
      bus.ram_mem_req   = 1'b0;
      bus.ram_mem_we    = 1'b0;
      bus.ram_mem_addr  = {`XLEN{1'b0}};
      bus.ram_mem_wdata = {`XLEN{1'b0}};
      bus.m0_mem_ready  = 1'b0;
      bus.m0_mem_rdata  = {`XLEN{1'b0}};
      bus.m1_mem_ready  = 1'b0;
      bus.m1_mem_rdata  = {`XLEN{1'b0}};
      if (state_r == BUSY && own_req_s && !abort_s) begin
         bus.ram_mem_req   = 1'b1;
         bus.ram_mem_we    = own_we_s;
         bus.ram_mem_addr  = own_addr_s;
         bus.ram_mem_wdata = own_wdata_s;
      end else begin
         bus.ram_mem_req   = 1'b0;
      end
      if ((done_s || abort_s) && grant_r[1]) begin
         bus.m1_mem_ready = 1'b1;
         bus.m1_mem_rdata = done_s ? bus.ram_mem_rdata : {`XLEN{1'b0}};
      end else if (done_s || abort_s) begin
         bus.m0_mem_ready = 1'b1;
         bus.m0_mem_rdata = done_s ? bus.ram_mem_rdata : {`XLEN{1'b0}};
      end else begin
         bus.m0_mem_ready = 1'b0;
      end
   end

   assign bus.grant       = grant_r;
   assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps against mem_arbiter (TIMEOUT=4) with immediate-assertion checks.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [`XLEN-1:0] obs, input logic [`XLEN-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   logic [1:0] exp_grant [4];

   initial begin
      n_total = 0;
      n_pass  = 0;
`ifdef ARB_RR_EN
      exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
      exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
      rst_n = 1'b0;
      bus.m0_mem_req = 1'b0; bus.m0_mem_we = 1'b0; bus.m0_mem_addr = 32'h0; bus.m0_mem_wdata = 32'h0;
      bus.m1_mem_req = 1'b0; bus.m1_mem_we = 1'b0; bus.m1_mem_addr = 32'h0; bus.m1_mem_wdata = 32'h0;
      bus.ram_mem_rdata = 32'h0; bus.ram_mem_ready = 1'b0;

      // reset state
      step(); step(); mid();
      chk("rst_grant", {30'd0, bus.grant}, 32'd0);
      chk("rst_terr", {31'd0, bus.timeout_err}, 32'd0);
      chk("rst_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      step(); rst_n = 1'b1;

      // single m0 read of 0x100
      bus.m0_mem_req = 1'b1; bus.m0_mem_addr = 32'h100;
      mid();
      chk("rd_idle_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      chk("rd_idle_grant", {30'd0, bus.grant}, 32'd0);
      step(); mid();
      chk("rd_grant", {30'd0, bus.grant}, 32'd1);
      chk("rd_ram_req", {31'd0, bus.ram_mem_req}, 32'd1);
      chk("rd_ram_addr", bus.ram_mem_addr, 32'h100);
      chk("rd_early_ready", {31'd0, bus.m0_mem_ready}, 32'd0);
      step(); bus.ram_mem_ready = 1'b1; bus.ram_mem_rdata = 32'hDEADBEEF;
      mid();
      chk("rd_m0_ready", {31'd0, bus.m0_mem_ready}, 32'd1);
      chk("rd_m0_rdata", bus.m0_mem_rdata, 32'hDEADBEEF);
      chk("rd_m1_ready", {31'd0, bus.m1_mem_ready}, 32'd0);
      chk("rd_m1_rdata", bus.m1_mem_rdata, 32'h0);
      step(); bus.m0_mem_req = 1'b0; bus.ram_mem_ready = 1'b0;
      mid();
      chk("rd_after_ready", {31'd0, bus.m0_mem_ready}, 32'd0);
      chk("rd_after_grant", {30'd0, bus.grant}, 32'd0);

      // fresh reset restores last-served=m1, then 4 contended accesses
      rst_n = 1'b0; step(); rst_n = 1'b1;
      bus.m0_mem_req = 1'b1; bus.m0_mem_addr = 32'h10;
      bus.m1_mem_req = 1'b1; bus.m1_mem_addr = 32'h20;
      bus.ram_mem_rdata = 32'hA5A5_0000;
      for (int i = 0; i < 4; i++) begin
         bus.ram_mem_ready = 1'b0;
         step(); bus.ram_mem_ready = 1'b1;
         mid();
         chk($sformatf("arb_grant_%0d", i), {30'd0, bus.grant}, {30'd0, exp_grant[i]});
         chk($sformatf("arb_addr_%0d", i), bus.ram_mem_addr, exp_grant[i][1] ? 32'h20 : 32'h10);
         chk($sformatf("arb_m0_ready_%0d", i), {31'd0, bus.m0_mem_ready}, {31'd0, exp_grant[i][0]});
         chk($sformatf("arb_m1_ready_%0d", i), {31'd0, bus.m1_mem_ready}, {31'd0, exp_grant[i][1]});
         step();
      end
      bus.m0_mem_req = 1'b0; bus.m1_mem_req = 1'b0; bus.ram_mem_ready = 1'b0;
      step();

      // m1 write with m0 arriving mid-transaction
      bus.m1_mem_req = 1'b1; bus.m1_mem_we = 1'b1; bus.m1_mem_addr = 32'h200; bus.m1_mem_wdata = 32'h55;
      step();
      bus.m0_mem_req = 1'b1; bus.m0_mem_we = 1'b0; bus.m0_mem_addr = 32'h300; bus.m0_mem_wdata = 32'hAA;
      mid();
      chk("wr_grant", {30'd0, bus.grant}, 32'd2);
      chk("wr_we", {31'd0, bus.ram_mem_we}, 32'd1);
      chk("wr_addr", bus.ram_mem_addr, 32'h200);
      chk("wr_wdata", bus.ram_mem_wdata, 32'h55);
      step(); mid();
      chk("wr_addr_hold", bus.ram_mem_addr, 32'h200);
      step(); bus.ram_mem_ready = 1'b1;
      mid();
      chk("wr_m1_ready", {31'd0, bus.m1_mem_ready}, 32'd1);
      chk("wr_m0_ready", {31'd0, bus.m0_mem_ready}, 32'd0);
      step(); bus.m1_mem_req = 1'b0; bus.m1_mem_we = 1'b0; bus.ram_mem_ready = 1'b0;
      mid();
      chk("wr_gap_grant", {30'd0, bus.grant}, 32'd0);
      chk("wr_gap_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      step(); mid();
      chk("wr_m0_grant", {30'd0, bus.grant}, 32'd1);
      chk("wr_m0_addr", bus.ram_mem_addr, 32'h300);
      step(); bus.m0_mem_req = 1'b0;

      // ready on the 4th BUSY cycle: completion wins over timeout
      step(); bus.m0_mem_req = 1'b1; bus.m0_mem_addr = 32'h400; bus.ram_mem_rdata = 32'h12345678;
      step(); step(); step(); step();
      bus.ram_mem_ready = 1'b1;
      mid();
      chk("tie_m0_ready", {31'd0, bus.m0_mem_ready}, 32'd1);
      chk("tie_m0_rdata", bus.m0_mem_rdata, 32'h12345678);
      step(); bus.m0_mem_req = 1'b0; bus.ram_mem_ready = 1'b0;
      mid();
      chk("tie_terr", {31'd0, bus.timeout_err}, 32'd0);

      // RAM never ready: abort on 4th BUSY cycle
      step(); bus.m0_mem_req = 1'b1;
      step();
      for (int i = 1; i <= 3; i++) begin
         mid();
         chk($sformatf("to_wait_ready_%0d", i), {31'd0, bus.m0_mem_ready}, 32'd0);
         chk($sformatf("to_wait_ram_req_%0d", i), {31'd0, bus.ram_mem_req}, 32'd1);
         step();
      end
      mid();
      chk("to_ready", {31'd0, bus.m0_mem_ready}, 32'd1);
      chk("to_rdata", bus.m0_mem_rdata, 32'h0);
      chk("to_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      step(); bus.m0_mem_req = 1'b0;
      mid();
      chk("to_terr", {31'd0, bus.timeout_err}, 32'd1);
      chk("to_grant", {30'd0, bus.grant}, 32'd0);
      bus.m1_mem_req = 1'b1;
      step(); bus.ram_mem_ready = 1'b1;
      mid();
      chk("to_good_m1_ready", {31'd0, bus.m1_mem_ready}, 32'd1);
      step(); bus.m1_mem_req = 1'b0; bus.ram_mem_ready = 1'b0;
      mid();
      chk("to_terr_sticky", {31'd0, bus.timeout_err}, 32'd1);

      // owner drops req during BUSY
      step(); bus.m0_mem_req = 1'b1;
      step(); bus.m0_mem_req = 1'b0; bus.ram_mem_ready = 1'b1;
      mid();
      chk("drop_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      chk("drop_ready", {31'd0, bus.m0_mem_ready}, 32'd0);
      step(); bus.ram_mem_ready = 1'b0;
      mid();
      chk("drop_grant", {30'd0, bus.grant}, 32'd0);

      // async reset during BUSY
      step(); bus.m0_mem_req = 1'b1;
      step(); mid();
      chk("ar_busy_ram_req", {31'd0, bus.ram_mem_req}, 32'd1);
      bus.ram_mem_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_ram_req", {31'd0, bus.ram_mem_req}, 32'd0);
      chk("ar_grant", {30'd0, bus.grant}, 32'd0);
      chk("ar_m0_ready", {31'd0, bus.m0_mem_ready}, 32'd0);
      chk("ar_terr", {31'd0, bus.timeout_err}, 32'd0);
      step(); bus.m0_mem_req = 1'b0; bus.ram_mem_ready = 1'b0; rst_n = 1'b1;
      mid();
      chk("ar_rel_grant", {30'd0, bus.grant}, 32'd0);
      step(); mid();
      chk("ar_rel_grant2", {30'd0, bus.grant}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
